// File: rtl/clk_div_prog.sv
// Runtime-programmable divider: divided clock (toggle or pulse) and a tick strobe.
// The divisor and mode are loaded through a valid/ready handshake and applied at a period boundary.
module clk_div_prog #(
    parameter int unsigned     WIDTH         = 17,
    parameter logic [WIDTH-1:0] DEFAULT_LIMIT = WIDTH'(59999),
    parameter logic            DEFAULT_MODE  = 1'b0
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic [WIDTH-1:0] div_value,
    input  logic             div_mode,
    output logic             clk_out,
    output logic             tick
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] limit_act;
    logic [WIDTH-1:0] limit_shd;
    logic             mode_act;
    logic             mode_shd;
    logic             pending;

    logic             term_c;
    logic             xfer_c;
    logic             apply_c;
    logic             clk_out_nxt_c;

    assign term_c    = en && (count == limit_act);
    assign xfer_c    = div_valid && !pending;
    // A held-off load is committed at a period boundary, or at once while counting is paused.
    assign apply_c   = pending && (term_c || !en);
    assign div_ready = ~pending;

    // Output level for the next edge; a mode change restarts the output low.
    always_comb begin
        clk_out_nxt_c = clk_out;
        if (apply_c && (mode_shd != mode_act)) begin
            clk_out_nxt_c = 1'b0;
        end else if (term_c) begin
            clk_out_nxt_c = mode_act ? 1'b1 : ~clk_out;
        end else if (en && mode_act) begin
            clk_out_nxt_c = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            count     <= '0;
            limit_act <= DEFAULT_LIMIT;
            mode_act  <= DEFAULT_MODE;
            limit_shd <= '0;
            mode_shd  <= 1'b0;
            pending   <= 1'b0;
            clk_out   <= 1'b0;
            tick      <= 1'b0;
        end else begin
            tick    <= term_c;
            clk_out <= clk_out_nxt_c;

            if (apply_c || term_c) begin
                count <= '0;
            end else if (en) begin
                count <= count + WIDTH'(1);
            end

            if (apply_c) begin
                limit_act <= limit_shd;
                mode_act  <= mode_shd;
                pending   <= 1'b0;
            end

            // apply_c needs pending=1 and xfer_c needs pending=0, so they never coincide.
            if (xfer_c) begin
                limit_shd <= div_value;
                mode_shd  <= div_mode;
                pending   <= 1'b1;
            end
        end
    end

endmodule
